ahb_slave_if: RTL and testbench



---
 rtl/bridge_pkg.sv | 29 ++
 rtl/ahb_slave_if_if.sv | 23 ++
 rtl/ahb_slave_if_decode.sv | 22 ++
 rtl/ahb_slave_if.sv | 130 +++++++++++++
 tb/tb_ahb_slave_if.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: AHB encodings, default
// peripheral windows and the AHB error-response state type.
package bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] BASE0_DEF    = 32'h8000_0000;
  localparam logic [31:0] BASE1_DEF    = 32'h8400_0000;
  localparam logic [31:0] BASE2_DEF    = 32'h8800_0000;
  localparam int          WIN_BITS_DEF = 26;

  typedef enum logic [1:0] {
    ERR_OKAY = 2'b00,
    ERR_1    = 2'b01,
    ERR_2    = 2'b10
  } err_state_e;

  // An AHB transfer is real only when the bus is ready and it is NONSEQ or SEQ.
  function automatic logic is_active(input logic [1:0] htrans, input logic hreadyin);
    return hreadyin && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/ahb_slave_if_if.sv
// AHB bus bundle between the AHB master and the bridge front end.
interface ahb_slave_if_if;

  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hwrite;
  logic [1:0]  Htrans;
  logic        Hreadyin;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;

  modport master (
    output Haddr, Hwdata, Hwrite, Htrans, Hreadyin,
    input  Hrdata, Hresp, Hreadyout
  );

  modport slave (
    input  Haddr, Hwdata, Hwrite, Htrans, Hreadyin,
    output Hrdata, Hresp, Hreadyout
  );

endinterface

// File: rtl/ahb_slave_if_decode.sv
// Combinational address decoder: Haddr to one-hot APB peripheral select.
module ahb_addr_decode
  import bridge_pkg::*;
#(
  parameter logic [31:0] BASE0    = BASE0_DEF,
  parameter logic [31:0] BASE1    = BASE1_DEF,
  parameter logic [31:0] BASE2    = BASE2_DEF,
  parameter int          WIN_BITS = WIN_BITS_DEF
) (
  input  logic [31:0] haddr,
  output logic [2:0]  tempselx
);

  // Only the bits above the window size identify a peripheral.
  always_comb begin
    tempselx    = 3'b000;
    tempselx[0] = (haddr[31:WIN_BITS] == BASE0[31:WIN_BITS]);
    tempselx[1] = (haddr[31:WIN_BITS] == BASE1[31:WIN_BITS]);
    tempselx[2] = (haddr[31:WIN_BITS] == BASE2[31:WIN_BITS]);
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification,
// address decode, address/data/direction pipeline and the ERROR response.
module ahb_slave_if
  import bridge_pkg::*;
#(
  parameter logic [31:0] BASE0    = BASE0_DEF,
  parameter logic [31:0] BASE1    = BASE1_DEF,
  parameter logic [31:0] BASE2    = BASE2_DEF,
  parameter int          WIN_BITS = WIN_BITS_DEF
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  ahb_slave_if_if.slave   ahb,
  input  logic [31:0]     Prdata,
  input  logic            apb_ready,
  output logic            valid,
  output logic [31:0]     Haddr1,
  output logic [31:0]     Haddr2,
  output logic [31:0]     Hwdata1,
  output logic [31:0]     Hwdata2,
  output logic            Hwritereg,
  output logic            Hwritereg1,
  output logic [2:0]      tempselx
);

  logic [31:0] haddr1_q, haddr1_d, haddr2_q, haddr2_d;
  logic [31:0] hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
  logic        hwritereg_q, hwritereg_d, hwritereg1_q, hwritereg1_d;
  err_state_e  err_q, err_d;
  logic        active_s;
  logic [1:0]  hresp_s;
  logic        hreadyout_s;

  ahb_addr_decode #(
    .BASE0    (BASE0),
    .BASE1    (BASE1),
    .BASE2    (BASE2),
    .WIN_BITS (WIN_BITS)
  ) u_decode (
    .haddr    (ahb.Haddr),
    .tempselx (tempselx)
  );

  // Transfers arriving during the ERROR response are ignored entirely.
  always_comb begin
    active_s = is_active(ahb.Htrans, ahb.Hreadyin);
    valid    = active_s && (tempselx != 3'b000) && (err_q == ERR_OKAY);
  end

  // Pipeline next state: advance on ready, otherwise hold.
  always_comb begin
    haddr1_d     = haddr1_q;
    haddr2_d     = haddr2_q;
    hwdata1_d    = hwdata1_q;
    hwdata2_d    = hwdata2_q;
    hwritereg_d  = hwritereg_q;
    hwritereg1_d = hwritereg1_q;
    if (ahb.Hreadyin) begin
      haddr1_d     = ahb.Haddr;
      haddr2_d     = haddr1_q;
      hwdata1_d    = ahb.Hwdata;
      hwdata2_d    = hwdata1_q;
      hwritereg_d  = ahb.Hwrite;
      hwritereg1_d = hwritereg_q;
    end else begin
      haddr1_d = haddr1_q;
    end
  end

  // Error FSM next state and AHB response; apb_ready only matters in OKAY.
  always_comb begin
    err_d       = err_q;
    hresp_s     = HRESP_OKAY;
    hreadyout_s = apb_ready;
    case (err_q)
      ERR_OKAY: begin
        if (active_s && (tempselx == 3'b000)) begin
          err_d = ERR_1;
        end else begin
          err_d = ERR_OKAY;
        end
      end
      ERR_1: begin
        err_d       = ERR_2;
        hresp_s     = HRESP_ERROR;
        hreadyout_s = 1'b0;
      end
      ERR_2: begin
        err_d       = ERR_OKAY;
        hresp_s     = HRESP_ERROR;
        hreadyout_s = 1'b1;
      end
      default: begin
        err_d = ERR_OKAY;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      haddr1_q     <= 32'h0000_0000;
      haddr2_q     <= 32'h0000_0000;
      hwdata1_q    <= 32'h0000_0000;
      hwdata2_q    <= 32'h0000_0000;
      hwritereg_q  <= 1'b0;
      hwritereg1_q <= 1'b0;
      err_q        <= ERR_OKAY;
    end else begin
      haddr1_q     <= haddr1_d;
      haddr2_q     <= haddr2_d;
      hwdata1_q    <= hwdata1_d;
      hwdata2_q    <= hwdata2_d;
      hwritereg_q  <= hwritereg_d;
      hwritereg1_q <= hwritereg1_d;
      err_q        <= err_d;
    end
  end

  assign Haddr1        = haddr1_q;
  assign Haddr2        = haddr2_q;
  assign Hwdata1       = hwdata1_q;
  assign Hwdata2       = hwdata2_q;
  assign Hwritereg     = hwritereg_q;
  assign Hwritereg1    = hwritereg1_q;
  assign ahb.Hrdata    = Prdata;
  assign ahb.Hresp     = hresp_s;
  assign ahb.Hreadyout = hreadyout_s;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios plus randomized
// traffic checked against a window/history-based reference model.
module tb_ahb_slave_if;

  logic        Hclk;
  logic        Hresetn;
  logic [31:0] Prdata;
  logic        apb_ready;
  logic        valid;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwritereg, Hwritereg1;
  logic [2:0]  tempselx;

  int checks = 0;
  int errors = 0;

  ahb_slave_if_if bus ();

  ahb_slave_if dut (
    .Hclk       (Hclk),
    .Hresetn    (Hresetn),
    .ahb        (bus),
    .Prdata     (Prdata),
    .apb_ready  (apb_ready),
    .valid      (valid),
    .Haddr1     (Haddr1),
    .Haddr2     (Haddr2),
    .Hwdata1    (Hwdata1),
    .Hwdata2    (Hwdata2),
    .Hwritereg  (Hwritereg),
    .Hwritereg1 (Hwritereg1),
    .tempselx   (tempselx)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Reference model: history of inputs seen on ready edges plus an
  // error-cycles-remaining counter.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } snap_t;

  snap_t       hist[$];
  int          err_left = 0;
  logic [31:0] bases[3];

  function automatic logic [2:0] m_sel(input logic [31:0] a);
    logic [2:0] s;
    longint unsigned lo, hi;
    s = 3'b000;
    for (int n = 0; n < 3; n++) begin
      lo = longint'(bases[n]);
      hi = lo + (64'd1 << 26) - 64'd1;
      if (longint'(a) >= lo && longint'(a) <= hi) s[n] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic m_active();
    return bus.Hreadyin && (bus.Htrans == 2'b10 || bus.Htrans == 2'b11);
  endfunction

  function automatic logic m_valid();
    return m_active() && (m_sel(bus.Haddr) != 3'b000) && (err_left == 0);
  endfunction

  function automatic logic [1:0] m_hresp();
    return (err_left != 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic m_hreadyout();
    if (err_left == 2) return 1'b0;
    if (err_left == 1) return 1'b1;
    return apb_ready;
  endfunction

  function automatic logic [31:0] h_addr(input int k);
    return (hist.size() > k) ? hist[k].addr : 32'h0;
  endfunction

  function automatic logic [31:0] h_wdata(input int k);
    return (hist.size() > k) ? hist[k].wdata : 32'h0;
  endfunction

  function automatic logic h_write(input int k);
    return (hist.size() > k) ? hist[k].write : 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    err_left = 0;
  endtask

  task automatic clk_edge();
    snap_t s;
    @(posedge Hclk);
    if (Hresetn) begin
      if (err_left > 0) err_left = err_left - 1;
      else if (m_active() && m_sel(bus.Haddr) == 3'b000) err_left = 2;
      if (bus.Hreadyin) begin
        s.addr  = bus.Haddr;
        s.wdata = bus.Hwdata;
        s.write = bus.Hwrite;
        hist.push_front(s);
        if (hist.size() > 4) void'(hist.pop_back());
      end
    end
    #1;
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic [31:0] d, input logic r);
    bus.Haddr = a; bus.Htrans = t; bus.Hwrite = w; bus.Hwdata = d; bus.Hreadyin = r;
  endtask

  task automatic test_reset();
    Hresetn = 1'b0; apb_ready = 1'b1; Prdata = 32'h1234_5678;
    model_reset();
    set_bus(32'h8000_0004, 2'b10, 1'b1, 32'hFFFF_FFFF, 1'b1);
    clk_edge(); clk_edge();
    checks++; if (Haddr1 !== 32'h0) begin errors++; $display("FAIL rst_haddr1: got %h expected 00000000", Haddr1); end
    checks++; if (Haddr2 !== 32'h0 || Hwdata1 !== 32'h0 || Hwdata2 !== 32'h0) begin errors++; $display("FAIL rst_pipe: got %h %h %h expected 0", Haddr2, Hwdata1, Hwdata2); end
    checks++; if ({Hwritereg, Hwritereg1} !== 2'b00) begin errors++; $display("FAIL rst_write: got %b%b expected 00", Hwritereg, Hwritereg1); end
    checks++; if (bus.Hresp !== 2'b00 || bus.Hreadyout !== 1'b1) begin errors++; $display("FAIL rst_resp: got %b/%b expected 00/1", bus.Hresp, bus.Hreadyout); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rst_valid: got %b expected 1", valid); end
    Hresetn = 1'b1;
    set_bus(32'h9000_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    clk_edge();
    set_bus(32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
    checks++; if (bus.Hresp !== 2'b01 || bus.Hreadyout !== 1'b0) begin errors++; $display("FAIL rst_err1: got %b/%b expected 01/0", bus.Hresp, bus.Hreadyout); end
    #2 Hresetn = 1'b0; model_reset();
    #1;
    checks++; if (bus.Hresp !== 2'b00 || bus.Hreadyout !== 1'b1) begin errors++; $display("FAIL rst_async: got %b/%b expected 00/1", bus.Hresp, bus.Hreadyout); end
    clk_edge();
    Hresetn = 1'b1;
  endtask

  task automatic test_single_write();
    apb_ready = 1'b1;
    set_bus(32'h8400_0010, 2'b10, 1'b1, 32'h0, 1'b1);
    #1;
    checks++; if (valid !== 1'b1 || tempselx !== 3'b010) begin errors++; $display("FAIL wr_decode: got %b/%b expected 1/010", valid, tempselx); end
    clk_edge();
    checks++; if (Haddr1 !== 32'h8400_0010 || Hwritereg !== 1'b1) begin errors++; $display("FAIL wr_stage1: got %h/%b expected 84000010/1", Haddr1, Hwritereg); end
    set_bus(32'h0, 2'b00, 1'b0, 32'hA5A5_0001, 1'b1);
    clk_edge();
    checks++; if (Hwdata1 !== 32'hA5A5_0001 || Haddr2 !== 32'h8400_0010) begin errors++; $display("FAIL wr_stage2: got %h/%h expected a5a50001/84000010", Hwdata1, Haddr2); end
    checks++; if (Hwritereg1 !== 1'b1) begin errors++; $display("FAIL wr_dir2: got %b expected 1", Hwritereg1); end
  endtask

  task automatic test_read();
    apb_ready = 1'b1; Prdata = 32'hDEAD_BEEF;
    set_bus(32'h8800_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (tempselx !== 3'b100 || bus.Hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %b/%h expected 100/deadbeef", tempselx, bus.Hrdata); end
    checks++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00) begin errors++; $display("FAIL rd_resp: got %b/%b expected 1/00", bus.Hreadyout, bus.Hresp); end
    apb_ready = 1'b0; #1;
    checks++; if (bus.Hreadyout !== 1'b0) begin errors++; $display("FAIL rd_wait: got %b expected 0", bus.Hreadyout); end
    apb_ready = 1'b1;
    clk_edge();
  endtask

  task automatic test_unmapped();
    apb_ready = 1'b1;
    set_bus(32'h9000_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (valid !== 1'b0 || tempselx !== 3'b000) begin errors++; $display("FAIL um_valid: got %b/%b expected 0/000", valid, tempselx); end
    clk_edge();
    set_bus(32'h8000_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (bus.Hresp !== 2'b01 || bus.Hreadyout !== 1'b0) begin errors++; $display("FAIL um_err1: got %b/%b expected 01/0", bus.Hresp, bus.Hreadyout); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL um_ign1: got %b expected 0", valid); end
    clk_edge();
    set_bus(32'h9000_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (bus.Hresp !== 2'b01 || bus.Hreadyout !== 1'b1) begin errors++; $display("FAIL um_err2: got %b/%b expected 01/1", bus.Hresp, bus.Hreadyout); end
    clk_edge();
    set_bus(32'h8000_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (bus.Hresp !== 2'b00 || bus.Hreadyout !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL um_okay: got %b/%b/%b expected 00/1/1", bus.Hresp, bus.Hreadyout, valid); end
    clk_edge();
  endtask

  task automatic test_wait_hold();
    set_bus(32'h8000_0000, 2'b10, 1'b1, 32'h0, 1'b1); clk_edge();
    set_bus(32'h8000_0004, 2'b11, 1'b1, 32'h0, 1'b1); clk_edge();
    checks++; if (Haddr1 !== 32'h8000_0004) begin errors++; $display("FAIL wt_beat2: got %h expected 80000004", Haddr1); end
    set_bus(32'h8000_0008, 2'b11, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      checks++; if (Haddr1 !== 32'h8000_0004 || Haddr2 !== 32'h8000_0000) begin errors++; $display("FAIL wt_hold%0d: got %h/%h expected 80000004/80000000", i, Haddr1, Haddr2); end
    end
    bus.Hreadyin = 1'b1; clk_edge();
    checks++; if (Haddr1 !== 32'h8000_0008) begin errors++; $display("FAIL wt_resume: got %h expected 80000008", Haddr1); end
    set_bus(32'h8000_000C, 2'b11, 1'b1, 32'h0, 1'b1); clk_edge();
    checks++; if (Haddr1 !== 32'h8000_000C || Haddr2 !== 32'h8000_0008) begin errors++; $display("FAIL wt_beat4: got %h/%h expected 8000000c/80000008", Haddr1, Haddr2); end
  endtask

  task automatic test_non_transfer();
    logic [1:0] tr;
    apb_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tr = (i == 0) ? 2'b00 : 2'b01;
      set_bus(32'h9000_0000 + 32'(i), tr, 1'b0, 32'h0, 1'b1);
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nt_valid%0d: got %b expected 0", i, valid); end
      clk_edge();
      checks++; if (bus.Hresp !== 2'b00 || Haddr1 !== 32'h9000_0000 + 32'(i)) begin errors++; $display("FAIL nt_noerr%0d: got %b/%h expected 00/%h", i, bus.Hresp, Haddr1, 32'h9000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] addrs[4];
    logic [2:0]  exps[4];
    addrs[0] = 32'h7FFF_FFFC; exps[0] = 3'b000;
    addrs[1] = 32'h83FF_FFFF; exps[1] = 3'b001;
    addrs[2] = 32'h8BFF_FFFC; exps[2] = 3'b100;
    addrs[3] = 32'h8C00_0000; exps[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      set_bus(addrs[i], 2'b00, 1'b0, 32'h0, 1'b1);
      #1;
      checks++; if (tempselx !== exps[i]) begin errors++; $display("FAIL bnd_%h: got %b expected %b", addrs[i], tempselx, exps[i]); end
    end
    clk_edge();
  endtask

  task automatic test_random();
    logic [31:0] a;
    int k;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, 5);
      case (k)
        0, 1, 2: a = bases[k] + ($urandom() & 32'h03FF_FFFF);
        3:       a = 32'h8C00_0000 + ($urandom() & 32'h0FFF_FFFF);
        4:       a = 32'h7FFF_FFFC;
        default: a = $urandom();
      endcase
      set_bus(a, 2'($urandom_range(0, 3)), 1'($urandom()), $urandom(), ($urandom_range(0, 3) != 0));
      apb_ready = 1'($urandom());
      Prdata    = $urandom();
      #1;
      checks++; if (tempselx !== m_sel(a) || valid !== m_valid()) begin errors++; $display("FAIL rnd_dec c%0d: got %b/%b expected %b/%b", c, tempselx, valid, m_sel(a), m_valid()); end
      checks++; if (bus.Hresp !== m_hresp() || bus.Hreadyout !== m_hreadyout() || bus.Hrdata !== Prdata) begin errors++; $display("FAIL rnd_resp c%0d: got %b/%b/%h expected %b/%b/%h", c, bus.Hresp, bus.Hreadyout, bus.Hrdata, m_hresp(), m_hreadyout(), Prdata); end
      clk_edge();
      checks++; if (Haddr1 !== h_addr(0) || Haddr2 !== h_addr(1)) begin errors++; $display("FAIL rnd_addr c%0d: got %h/%h expected %h/%h", c, Haddr1, Haddr2, h_addr(0), h_addr(1)); end
      checks++; if (Hwdata1 !== h_wdata(0) || Hwdata2 !== h_wdata(1)) begin errors++; $display("FAIL rnd_wdata c%0d: got %h/%h expected %h/%h", c, Hwdata1, Hwdata2, h_wdata(0), h_wdata(1)); end
      checks++; if (Hwritereg !== h_write(0) || Hwritereg1 !== h_write(1)) begin errors++; $display("FAIL rnd_dir c%0d: got %b/%b expected %b/%b", c, Hwritereg, Hwritereg1, h_write(0), h_write(1)); end
    end
  endtask

  initial begin
    bases[0] = 32'h8000_0000;
    bases[1] = 32'h8400_0000;
    bases[2] = 32'h8800_0000;
    Hresetn = 1'b0; apb_ready = 1'b0; Prdata = 32'h0;
    set_bus(32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    #1;
    test_reset();
    test_single_write();
    test_read();
    test_unmapped();
    test_wait_hold();
    test_non_transfer();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
